draw_sprite: RTL and testbench

Parametrised sprite renderer for the VGA pipeline: overlays a ROM-backed, multi-frame animated sprite onto the incoming vga_if stream at a frame-latched position, with optional horizontal mirroring and colour-key transparency. It generalises the fixed-size character drawer so that each game character instantiates this block with its own geometry, frame count and animation rate. It sits between the background/previous-layer stage and the next overlay stage and drives the address of a synchronous sprite ROM.

---
 rtl/draw_sprite.sv | 196 +++++++++++++++++++
 tb/tb_draw_sprite.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sprite.sv
// draw_sprite
//   Overlays a ROM-backed, multi-frame animated sprite onto a VGA stream.
//   Sprite position, mirroring and visibility are sampled once per video
//   frame (rising edge of vblnk) so the sprite never tears mid-frame.
//   The sprite ROM is synchronous: pixel_addr is issued one clock after a
//   pixel enters, and the ROM word returns alongside the delayed timing.
//
// Ports
//   clk, rst          pixel clock, synchronous active-high reset
//   xpos, ypos        requested sprite top-left corner
//   mirror            draw horizontally flipped
//   visible           draw the sprite at all
//   anim_en           let the animation advance
//   rgb_pixel         ROM data (one clock after pixel_addr)
//   pixel_addr        ROM address {frame, row, col}
//   frame_idx         current animation frame
//   in_*              upstream timing/colour (hcount, hsync, hblnk,
//                     vcount, vsync, vblnk, rgb)
//   out_*             the same fields, 3 clocks later, with sprite overlaid
module draw_sprite #(
  parameter int          SPRITE_W    = 48,
  parameter int          SPRITE_H    = 64,
  parameter int          FRAMES      = 4,
  parameter int          FRAME_TICKS = 8,
  parameter logic [11:0] KEY_RGB     = 12'h0_0_0,
  parameter logic [11:0] BLANK_RGB   = 12'h8_8_8,
  localparam int COL_W  = $clog2(SPRITE_W),
  localparam int ROW_W  = $clog2(SPRITE_H),
  localparam int FRM_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int ADDR_W = FRM_W + ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              mirror,
  input  logic              visible,
  input  logic              anim_en,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [FRM_W-1:0]  frame_idx,
  input  logic [11:0]       in_hcount,
  input  logic              in_hsync,
  input  logic              in_hblnk,
  input  logic [11:0]       in_vcount,
  input  logic              in_vsync,
  input  logic              in_vblnk,
  input  logic [11:0]       in_rgb,
  output logic [11:0]       out_hcount,
  output logic              out_hsync,
  output logic              out_hblnk,
  output logic [11:0]       out_vcount,
  output logic              out_vsync,
  output logic              out_vblnk,
  output logic [11:0]       out_rgb
);

  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  // ---------------- frame latch and animation ----------------
  logic              vblnk_q;
  logic              armed;
  logic              frame_start;
  logic [11:0]       xl, yl;
  logic              ml, vl;
  logic [TICK_W-1:0] tick;

  // armed only sets once vblnk has been seen low, so leaving reset in the
  // middle of vertical blanking does not count as a frame start.
  assign frame_start = in_vblnk & ~vblnk_q & armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q   <= 1'b0;
      armed     <= 1'b0;
      xl        <= '0;
      yl        <= '0;
      ml        <= 1'b0;
      vl        <= 1'b0;
      tick      <= '0;
      frame_idx <= '0;
    end else begin
      vblnk_q <= in_vblnk;
      if (!in_vblnk) armed <= 1'b1;
      if (frame_start) begin
        xl <= xpos;
        yl <= ypos;
        ml <= mirror;
        vl <= visible;
        if (anim_en) begin
          if (tick == TICK_W'(FRAME_TICKS - 1)) begin
            tick      <= '0;
            frame_idx <= (frame_idx == FRM_W'(FRAMES - 1)) ? '0
                                                           : frame_idx + FRM_W'(1);
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
      end
    end
  end

  // ---------------- stage 1: ROM address ----------------
  // Computed unconditionally; the hit test in stage 2 discards it outside
  // the sprite box.
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col_raw, col;

  assign row     = ROW_W'(in_vcount - yl);
  assign col_raw = COL_W'(in_hcount - xl);
  assign col     = ml ? COL_W'(SPRITE_W - 1) - col_raw : col_raw;

  // ---------------- timing delay line ----------------
  logic [11:0] d1_hcount, d1_vcount, d1_rgb;
  logic        d1_hsync, d1_hblnk, d1_vsync, d1_vblnk;
  logic [11:0] hcount_buf, vcount_buf, rgb_buf;
  logic        hsync_buf, hblnk_buf, vsync_buf, vblnk_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= '0;
      d1_hcount  <= '0;
      d1_hsync   <= 1'b0;
      d1_hblnk   <= 1'b0;
      d1_vcount  <= '0;
      d1_vsync   <= 1'b0;
      d1_vblnk   <= 1'b0;
      d1_rgb     <= '0;
      hcount_buf <= '0;
      hsync_buf  <= 1'b0;
      hblnk_buf  <= 1'b0;
      vcount_buf <= '0;
      vsync_buf  <= 1'b0;
      vblnk_buf  <= 1'b0;
      rgb_buf    <= '0;
    end else begin
      pixel_addr <= {frame_idx, row, col};
      d1_hcount  <= in_hcount;
      d1_hsync   <= in_hsync;
      d1_hblnk   <= in_hblnk;
      d1_vcount  <= in_vcount;
      d1_vsync   <= in_vsync;
      d1_vblnk   <= in_vblnk;
      d1_rgb     <= in_rgb;
      hcount_buf <= d1_hcount;
      hsync_buf  <= d1_hsync;
      hblnk_buf  <= d1_hblnk;
      vcount_buf <= d1_vcount;
      vsync_buf  <= d1_vsync;
      vblnk_buf  <= d1_vblnk;
      rgb_buf    <= d1_rgb;
    end
  end

  // ---------------- stage 2: hit test and colour ----------------
  // Box ends are 13 bits wide so a sprite near x/y = 4095 clips at the
  // screen edge instead of wrapping around to 0.
  logic [12:0] x_end, y_end;
  logic        hit;
  logic [11:0] rgb_sel;

  assign x_end = {1'b0, xl} + 13'(SPRITE_W);
  assign y_end = {1'b0, yl} + 13'(SPRITE_H);
  assign hit   = vl
               & (vcount_buf >= yl) & ({1'b0, vcount_buf} < y_end)
               & (hcount_buf >= xl) & ({1'b0, hcount_buf} < x_end);

  always_comb begin
    rgb_sel = rgb_buf;
    if (vblnk_buf | hblnk_buf)
      rgb_sel = BLANK_RGB;
    else if (hit && (rgb_pixel != KEY_RGB))
      rgb_sel = rgb_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_hcount <= '0;
      out_hsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_vcount <= '0;
      out_vsync  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_rgb    <= '0;
    end else begin
      out_hcount <= hcount_buf;
      out_hsync  <= hsync_buf;
      out_hblnk  <= hblnk_buf;
      out_vcount <= vcount_buf;
      out_vsync  <= vsync_buf;
      out_vblnk  <= vblnk_buf;
      out_rgb    <= rgb_sel;
    end
  end

endmodule

// File: tb/tb_draw_sprite.sv
module tb_draw_sprite;
  localparam int          SW    = 48;
  localparam int          SH    = 64;
  localparam int          FR    = 4;
  localparam int          FT    = 8;
  localparam logic [11:0] KEY   = 12'h000;
  localparam logic [11:0] BLANK = 12'h888;

  typedef struct packed {
    logic [11:0] h;
    logic        hs;
    logic        hb;
    logic [11:0] v;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } vga_t;

  typedef struct {
    int          cfg;
    int          h;
    int          v;
    logic        hb;
    logic [11:0] bg;
    logic [11:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0, ypos = '0;
  logic        mirror = 1'b0, visible = 1'b0, anim_en = 1'b0;
  logic [11:0] rgb_pixel = '0;
  logic [13:0] pixel_addr;
  logic [1:0]  frame_idx;
  logic [11:0] in_hcount = '0, in_vcount = '0, in_rgb = '0;
  logic        in_hsync = 1'b0, in_hblnk = 1'b0, in_vsync = 1'b0, in_vblnk = 1'b0;
  logic [11:0] out_hcount, out_vcount, out_rgb;
  logic        out_hsync, out_hblnk, out_vsync, out_vblnk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_sprite #(.SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(FR), .FRAME_TICKS(FT),
                .KEY_RGB(KEY), .BLANK_RGB(BLANK)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .mirror(mirror),
    .visible(visible), .anim_en(anim_en), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr), .frame_idx(frame_idx),
    .in_hcount(in_hcount), .in_hsync(in_hsync), .in_hblnk(in_hblnk),
    .in_vcount(in_vcount), .in_vsync(in_vsync), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
    .out_hcount(out_hcount), .out_hsync(out_hsync), .out_hblnk(out_hblnk),
    .out_vcount(out_vcount), .out_vsync(out_vsync), .out_vblnk(out_vblnk), .out_rgb(out_rgb)
  );

  // Sprite ROM contents: never equal to the key except at (row 5, col 5).
  function automatic logic [11:0] rom_word(logic [1:0] f, logic [5:0] r, logic [5:0] c);
    if (r == 6'd5 && c == 6'd5) return KEY;
    return {1'b1, f, r[2:0], c};
  endfunction

  always @(posedge clk)
    rgb_pixel <= rom_word(pixel_addr[13:12], pixel_addr[11:6], pixel_addr[5:0]);

  // ---------------- reference model ----------------
  int          m_x, m_y, m_starts, m_frame;
  logic        m_m, m_v, m_prev_vb;
  vga_t        exp_q[$];
  bit          started = 0;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_m = 0; m_v = 0;
    m_starts = 0; m_frame = 0;
    m_prev_vb = 1'b1;
  endtask

  task automatic model_pixel(input vga_t p, output vga_t e);
    int r, c;
    if (p.vb && !m_prev_vb) begin
      m_x = int'(xpos); m_y = int'(ypos); m_m = mirror; m_v = visible;
      if (anim_en) m_starts++;
      m_frame = (m_starts / FT) % FR;
    end
    m_prev_vb = p.vb;
    e = p;
    if (p.vb || p.hb) begin
      e.rgb = BLANK;
    end else if (m_v && int'(p.v) >= m_y && int'(p.v) < m_y + SH &&
                 int'(p.h) >= m_x && int'(p.h) < m_x + SW) begin
      r = int'(p.v) - m_y;
      c = int'(p.h) - m_x;
      if (m_m) c = SW - 1 - c;
      if (rom_word(2'(m_frame), 6'(r), 6'(c)) != KEY)
        e.rgb = rom_word(2'(m_frame), 6'(r), 6'(c));
    end
  endtask

  // One pixel per clock: check the pixel from 3 clocks ago, then drive.
  task automatic step(input vga_t p, input logic r, input logic use_tab,
                      input logic [11:0] tab_rgb);
    vga_t e, got;
    if (started) begin
      if (exp_q.size() == 3) begin
        e   = exp_q.pop_front();
        got = {out_hcount, out_hsync, out_hblnk, out_vcount, out_vsync, out_vblnk, out_rgb};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL out_vga actual=%h required=%h (h=%0d v=%0d)", got, e, e.h, e.v);
        end
      end
      checks++;
      if (frame_idx !== 2'(m_frame)) begin
        errors++;
        $display("FAIL frame_idx actual=%0d required=%0d", frame_idx, m_frame);
      end
    end
    started = 1;
    {in_hcount, in_hsync, in_hblnk, in_vcount, in_vsync, in_vblnk, in_rgb} = p;
    rst = r;
    if (r) begin
      foreach (exp_q[i]) exp_q[i] = '0;
      exp_q.push_back('0);
      model_reset();
    end else begin
      model_pixel(p, e);
      if (use_tab) e.rgb = tab_rgb;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic vga_t px(int h, int v, logic hb, logic [11:0] rgb);
    vga_t p = '0;
    p.h = 12'(h); p.v = 12'(v); p.hb = hb; p.rgb = rgb;
    return p;
  endfunction

  task automatic new_frame();
    vga_t p;
    p = px(1000, 700, 1'b1, 12'h000);
    step(p, 0, 0, 0);
    p.vb = 1'b1;
    repeat (3) step(p, 0, 0, 0);
    p.vs = 1'b1;
    step(p, 0, 0, 0);
  endtask

  task automatic do_reset(int n);
    repeat (n) step(px(0, 0, 1'b0, 12'h000), 1, 0, 0);
  endtask

  task automatic chk_frame(string name, int req);
    checks++;
    if (frame_idx !== 2'(req)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, frame_idx, req);
    end
  endtask

  vec_t vecs[] = '{
    '{0, 100,  50, 0, 12'hABC, 12'h800},
    '{0, 147,  50, 0, 12'hABC, 12'h82F},
    '{0, 148,  50, 0, 12'hABC, 12'hABC},
    '{0,  99,  50, 0, 12'h123, 12'h123},
    '{0, 100,  55, 0, 12'hABC, 12'h940},
    '{0, 105,  55, 0, 12'hABC, 12'hABC},
    '{0, 106,  55, 0, 12'hABC, 12'h946},
    '{0, 100, 113, 0, 12'hABC, 12'h9C0},
    '{0, 100, 114, 0, 12'hABC, 12'hABC},
    '{0, 120,  60, 1, 12'hABC, 12'h888},
    '{1, 100,  50, 0, 12'hABC, 12'h82F},
    '{1, 147,  50, 0, 12'hABC, 12'h800},
    '{1, 105,  55, 0, 12'hABC, 12'h96A},
    '{1, 142,  55, 0, 12'hABC, 12'hABC},
    '{1, 148,  50, 0, 12'hDEF, 12'hDEF},
    '{2,4080,  50, 0, 12'hABC, 12'h800},
    '{2,4095,  50, 0, 12'hABC, 12'h80F},
    '{2,   0,  50, 0, 12'h111, 12'h111},
    '{2,  31,  50, 0, 12'h222, 12'h222},
    '{2,4079,  50, 0, 12'h333, 12'h333}
  };

  int ak[4] = '{7, 8, 16, 24};
  int av[4] = '{0, 1, 2, 3};

  initial begin
    int   cfg_now;
    int   bx, by;
    vga_t p;
    model_reset();
    do_reset(4);

    // ---- table-driven: basic draw, mirror, colour key, blanking, clipping ----
    anim_en = 1'b0; visible = 1'b1; ypos = 12'd50;
    cfg_now = -1;
    foreach (vecs[i]) begin
      if (vecs[i].cfg != cfg_now) begin
        cfg_now = vecs[i].cfg;
        xpos   = (cfg_now == 2) ? 12'd4080 : 12'd100;
        mirror = (cfg_now == 1);
        new_frame();
      end
      step(px(vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].bg), 0, 1, vecs[i].exp);
    end

    // ---- frame latch: xpos change mid-frame takes effect next frame ----
    xpos = 12'd100; mirror = 1'b0;
    new_frame();
    step(px(100, 59, 1'b0, 12'h456), 0, 1, 12'h800 | 12'(9 & 7) << 6);
    xpos = 12'd200;
    step(px(100, 60, 1'b0, 12'h456), 0, 1, 12'h880);
    step(px(200, 60, 1'b0, 12'h456), 0, 1, 12'h456);
    new_frame();
    step(px(200, 60, 1'b0, 12'h456), 0, 1, 12'h880);
    step(px(100, 60, 1'b0, 12'h456), 0, 1, 12'h456);

    // ---- reset mid-line: zeros next clock, sprite hidden until frame start ----
    step(px(205, 60, 1'b0, 12'h456), 0, 0, 0);
    step(px(206, 60, 1'b0, 12'h456), 0, 0, 0);
    do_reset(2);
    step(px(200, 60, 1'b0, 12'hABC), 0, 1, 12'hABC);
    step(px(210, 61, 1'b0, 12'hABC), 0, 1, 12'hABC);
    // vblnk already high when reset releases: no frame start
    do_reset(2);
    p = px(0, 700, 1'b0, 12'h000); p.vb = 1'b1;
    repeat (3) step(p, 0, 0, 0);
    step(px(200, 60, 1'b0, 12'h5A5), 0, 1, 12'h5A5);
    new_frame();
    step(px(200, 60, 1'b0, 12'h5A5), 0, 1, 12'h880);

    // ---- animation sequence and freeze ----
    do_reset(2);
    anim_en = 1'b1; visible = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      new_frame();
      foreach (ak[j]) if (ak[j] == k) chk_frame("anim_step", av[j]);
    end
    anim_en = 1'b0;
    repeat (10) new_frame();
    chk_frame("anim_freeze", 3);
    anim_en = 1'b1;
    repeat (6) new_frame();
    chk_frame("anim_wrap", 0);

    // ---- randomized frames against the model ----
    for (int f = 0; f < 16; f++) begin
      xpos    = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4030, 4095))
                                            : 12'($urandom_range(0, 4095));
      ypos    = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4030, 4095))
                                            : 12'($urandom_range(0, 4095));
      mirror  = 1'($urandom);
      visible = ($urandom_range(0, 4) != 0);
      anim_en = 1'($urandom);
      bx = int'(xpos); by = int'(ypos);
      new_frame();
      for (int i = 0; i < 250; i++) begin
        p = px(bx + int'($urandom_range(0, 90)) - 20,
               by + int'($urandom_range(0, 80)) - 8,
               ($urandom_range(0, 15) == 0), 12'($urandom));
        p.hs = p.hb & 1'($urandom);
        if (i == 120) xpos = 12'($urandom);
        if (f == 9 && i == 100) do_reset(2);
        step(p, 0, 0, 0);
      end
    end

    p = px(0, 0, 1'b1, 12'h000);
    repeat (4) step(p, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
